// File: rtl/fifo_cdc_pkg.sv
// Shared async-FIFO helpers: pointer width default and Gray/binary conversion.
// Functions work on 32-bit zero-extended values; callers cast to pointer width.
package fifo_cdc_pkg;
    localparam int DEF_ADDR_WIDTH = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
endpackage

// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle between producer logic and the write-pointer/full block.
interface fifo_wptr_full_if
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  p_winc;
    logic [ADDR_WIDTH:0]   p_rptr_gray_sync;
    logic                  p_clr_ovf;
    logic                  p_wen;
    logic [ADDR_WIDTH-1:0] p_waddr;
    logic [ADDR_WIDTH:0]   p_wptr_gray;
    logic                  p_wfull;
    logic                  p_walmost_full;
    logic [ADDR_WIDTH:0]   p_wlevel;
    logic                  p_woverflow;

    modport slave (
        input  p_winc, p_rptr_gray_sync, p_clr_ovf,
        output p_wen, p_waddr, p_wptr_gray, p_wfull, p_walmost_full, p_wlevel, p_woverflow
    );

    modport master (
        output p_winc, p_rptr_gray_sync, p_clr_ovf,
        input  p_wen, p_waddr, p_wptr_gray, p_wfull, p_walmost_full, p_wlevel, p_woverflow
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write pointer and full/level logic; flags update one cycle after a write.
// Writes are dropped while full (p_wen low) and flagged in the sticky overflow bit.
module fifo_wptr_full
    import fifo_cdc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    fifo_wptr_full_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_cmp;

    assign bus.p_wen   = bus.p_winc & ~bus.p_wfull;
    assign bus.p_waddr = wbin[ADDR_WIDTH-1:0];

    assign wbin_next  = wbin + PW'(bus.p_wen);
    assign gray_next  = PW'(bin2gray(32'(wbin_next)));
    assign rbin       = PW'(gray2bin(32'(bus.p_rptr_gray_sync)));
    assign level_next = wbin_next - rbin;

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    // Requires ADDR_WIDTH >= 2.
    assign full_cmp = {~bus.p_rptr_gray_sync[PW-1:PW-2], bus.p_rptr_gray_sync[PW-3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin               <= '0;
            bus.p_wptr_gray    <= '0;
            bus.p_wfull        <= 1'b0;
            bus.p_walmost_full <= 1'b0;
            bus.p_wlevel       <= '0;
            bus.p_woverflow    <= 1'b0;
        end else begin
            wbin               <= wbin_next;
            bus.p_wptr_gray    <= gray_next;
            bus.p_wfull        <= (gray_next == full_cmp);
            bus.p_walmost_full <= (int'(level_next) >= AF_THRESH);
            bus.p_wlevel       <= level_next;
            // Set wins over clear so a concurrent overflow is never lost.
            if (bus.p_winc && bus.p_wfull) begin
                bus.p_woverflow <= 1'b1;
            end else if (bus.p_clr_ovf) begin
                bus.p_woverflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full at ADDR_WIDTH=2, AF_THRESH=3.
module tb_fifo_wptr_full;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    fifo_wptr_full_if #(.ADDR_WIDTH(2)) bus ();

    fifo_wptr_full #(.ADDR_WIDTH(2), .AF_THRESH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] fill_gray [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
    logic [2:0] wrap_rptr [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [2:0] wrap_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.p_winc = 1'b0;
        bus.p_clr_ovf = 1'b0;
        bus.p_rptr_gray_sync = 3'b000;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic write_n(input int n);
        bus.p_winc = 1'b1;
        repeat (n) tick();
        bus.p_winc = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        write_n(2);
        bus.p_winc = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.p_wptr_gray, bus.p_wfull, bus.p_walmost_full, bus.p_wlevel, bus.p_woverflow} !== 9'd0) begin
            failures++;
            $display("FAIL reset_regs got=%b want=0", {bus.p_wptr_gray, bus.p_wfull, bus.p_walmost_full, bus.p_wlevel, bus.p_woverflow});
        end
        checks++;
        if (bus.p_wen !== 1'b1) begin
            failures++;
            $display("FAIL reset_wen got=%b want=1", bus.p_wen);
        end
        checks++;
        if (bus.p_waddr !== 2'd0) begin
            failures++;
            $display("FAIL reset_waddr got=%0d want=0", bus.p_waddr);
        end
        bus.p_winc = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.p_winc = 1'b1;
        tick();
        bus.p_winc = 1'b0;
        checks++;
        if (bus.p_wptr_gray !== 3'b001) begin
            failures++;
            $display("FAIL resume_gray got=%b want=001", bus.p_wptr_gray);
        end
    endtask

    task automatic test_fill();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.p_winc = 1'b1;
            #1;
            checks++;
            if (bus.p_waddr !== 2'(i) || bus.p_wen !== 1'b1) begin
                failures++;
                $display("FAIL fill_waddr[%0d] got=%0d wen=%b want=%0d wen=1", i, bus.p_waddr, bus.p_wen, i);
            end
            tick();
            checks++;
            if (bus.p_wptr_gray !== fill_gray[i]) begin
                failures++;
                $display("FAIL fill_gray[%0d] got=%b want=%b", i, bus.p_wptr_gray, fill_gray[i]);
            end
            checks++;
            if (bus.p_walmost_full !== (i >= 2) || bus.p_wfull !== (i == 3) || bus.p_wlevel !== 3'(i + 1)) begin
                failures++;
                $display("FAIL fill_flags[%0d] got=af%b f%b lvl%0d want=af%b f%b lvl%0d",
                         i, bus.p_walmost_full, bus.p_wfull, bus.p_wlevel, (i >= 2), (i == 3), i + 1);
            end
        end
        bus.p_winc = 1'b0;
    endtask

    task automatic test_overflow();
        bus.p_winc = 1'b1;
        #1;
        checks++;
        if (bus.p_wen !== 1'b0) begin
            failures++;
            $display("FAIL ovf_wen got=%b want=0", bus.p_wen);
        end
        tick();
        bus.p_winc = 1'b0;
        checks++;
        if (bus.p_wptr_gray !== 3'b110 || bus.p_woverflow !== 1'b1 || bus.p_wfull !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set got=g%b o%b f%b want=g110 o1 f1", bus.p_wptr_gray, bus.p_woverflow, bus.p_wfull);
        end
        bus.p_clr_ovf = 1'b1;
        tick();
        bus.p_clr_ovf = 1'b0;
        checks++;
        if (bus.p_woverflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b want=0", bus.p_woverflow);
        end
    endtask

    task automatic test_drain();
        bus.p_rptr_gray_sync = 3'b001;
        tick();
        checks++;
        if (bus.p_wfull !== 1'b0 || bus.p_wlevel !== 3'd3 || bus.p_walmost_full !== 1'b1) begin
            failures++;
            $display("FAIL drain got=f%b lvl%0d af%b want=f0 lvl3 af1", bus.p_wfull, bus.p_wlevel, bus.p_walmost_full);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bus.p_winc = 1'b1;
            bus.p_rptr_gray_sync = wrap_rptr[i];
            tick();
            checks++;
            if (bus.p_wptr_gray !== wrap_gray[i] || bus.p_wfull !== 1'b0 || bus.p_wlevel !== 3'd1) begin
                failures++;
                $display("FAIL wrap[%0d] got=g%b f%b lvl%0d want=g%b f0 lvl1",
                         i, bus.p_wptr_gray, bus.p_wfull, bus.p_wlevel, wrap_gray[i]);
            end
        end
        bus.p_winc = 1'b0;
        #1;
        checks++;
        if (bus.p_waddr !== 2'd0) begin
            failures++;
            $display("FAIL wrap_waddr got=%0d want=0", bus.p_waddr);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        write_n(4);
        bus.p_winc = 1'b1;
        bus.p_clr_ovf = 1'b1;
        tick();
        checks++;
        if (bus.p_woverflow !== 1'b1) begin
            failures++;
            $display("FAIL simul_set got=%b want=1", bus.p_woverflow);
        end
        tick();
        checks++;
        if (bus.p_woverflow !== 1'b1) begin
            failures++;
            $display("FAIL simul_hold got=%b want=1", bus.p_woverflow);
        end
        bus.p_winc = 1'b0;
        tick();
        bus.p_clr_ovf = 1'b0;
        checks++;
        if (bus.p_woverflow !== 1'b0) begin
            failures++;
            $display("FAIL simul_clear got=%b want=0", bus.p_woverflow);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.p_winc = 1'b0;
        bus.p_clr_ovf = 1'b0;
        bus.p_rptr_gray_sync = 3'b000;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
